// File: rtl/mem_line_read_responder.sv
// mem_line_read_responder
//
// Memory-side AXI read responder for the cache line-fill path. Accepts one AR
// request at a time, reads the addressed 512-bit line from a line-wide backing
// port, then returns it as eight 64-bit R beats, critical word first, wrapping
// within the line. Beat k carries line word (start+k) mod 8, where word j sits
// at line bits [511-64j -: 64].
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   araddr_i ..       AR channel (addr, len, burst, valid) / arready_o
//   rdata_o ..        R channel (data, resp, last, valid) / rready_i
//   line_rden_o       one-cycle read strobe to the backing store
//   line_raddr_o      line address (latched araddr[31:6])
//   line_rdata_i      backing line data, valid the cycle after line_rden_o
//
// Malformed requests (len != 7, reserved burst, unaligned INCR) are answered
// with len+1 all-zero SLVERR beats and never touch the backing store.

module mem_line_read_responder #(
  parameter int unsigned LATENCY = 4  // AR handshake to first rvalid_o, 3..255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  araddr_i,
  input  logic [3:0]   arlen_i,
  input  logic [1:0]   arburst_i,
  input  logic         arvalid_i,
  output logic         arready_o,
  output logic [63:0]  rdata_o,
  output logic [1:0]   rresp_o,
  output logic         rlast_o,
  output logic         rvalid_o,
  input  logic         rready_i,
  output logic         line_rden_o,
  output logic [25:0]  line_raddr_o,
  input  logic [511:0] line_rdata_i
);

  typedef enum logic [2:0] {StIdle, StWait, StFetch, StLoad, StSend} state_e;

  // FETCH and LOAD account for two of the latency cycles, the handshake for one.
  localparam logic [7:0] WaitInit = 8'(LATENCY - 3);

  state_e       state_q, state_d;
  logic [25:0]  line_q, line_d;
  logic [2:0]   start_q, start_d;
  logic [3:0]   len_q, len_d;
  logic         err_q, err_d;
  logic [7:0]   wcnt_q, wcnt_d;
  logic [511:0] buf_q, buf_d;
  logic [3:0]   bcnt_q, bcnt_d;
  logic [2:0]   wptr_q, wptr_d;

  logic ar_err;
  logic unused_addr_bits;

  // Byte offset within a beat carries no information for whole-line reads.
  assign unused_addr_bits = ^araddr_i[2:0];

  assign ar_err = (arlen_i != 4'd7) ||
                  !((arburst_i == 2'b01) || (arburst_i == 2'b10)) ||
                  ((arburst_i == 2'b01) && (araddr_i[5:3] != 3'd0));

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    start_d = start_q;
    len_d   = len_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    buf_d   = buf_q;
    bcnt_d  = bcnt_q;
    wptr_d  = wptr_q;
    case (state_q)
      StIdle: begin
        if (arvalid_i) begin
          line_d  = araddr_i[31:6];
          start_d = araddr_i[5:3];
          len_d   = arlen_i;
          err_d   = ar_err;
          wcnt_d  = WaitInit;
          state_d = (WaitInit != 8'd0) ? StWait : StFetch;
        end
      end
      StWait: begin
        wcnt_d = wcnt_q - 8'd1;
        if (wcnt_q == 8'd1) state_d = StFetch;
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        buf_d   = err_q ? '0 : line_rdata_i;
        bcnt_d  = 4'd0;
        wptr_d  = start_q;
        state_d = StSend;
      end
      StSend: begin
        if (rready_i) begin
          bcnt_d = bcnt_q + 4'd1;
          wptr_d = wptr_q + 3'd1;  // wraps 7 -> 0 within the line
          if (bcnt_q == len_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      line_q  <= '0;
      start_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      buf_q   <= '0;
      bcnt_q  <= '0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      start_q <= start_d;
      len_q   <= len_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      buf_q   <= buf_d;
      bcnt_q  <= bcnt_d;
      wptr_q  <= wptr_d;
    end
  end

  // All outputs decode registered state only; R payload is zero when idle.
  always_comb begin
    arready_o    = (state_q == StIdle);
    rvalid_o     = (state_q == StSend);
    line_rden_o  = (state_q == StFetch) && !err_q;
    line_raddr_o = line_q;
    rdata_o      = '0;
    rresp_o      = 2'b00;
    rlast_o      = 1'b0;
    if (rvalid_o) begin
      // Word j lives at base 64*(7-j) = {~j, 6'b0}.
      rdata_o = buf_q[{~wptr_q, 6'b0} +: 64];
      rresp_o = err_q ? 2'b10 : 2'b00;
      rlast_o = (bcnt_q == len_q);
    end
  end

endmodule

// File: tb/tb_mem_line_read_responder.sv
module tb_mem_line_read_responder;

  localparam int unsigned LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  araddr;
  logic [3:0]   arlen;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready_o;
  logic [63:0]  rdata_o;
  logic [1:0]   rresp_o;
  logic         rlast_o;
  logic         rvalid_o;
  logic         rready;
  logic         line_rden_o;
  logic [25:0]  line_raddr_o;
  logic [511:0] line_rdata_i;

  logic [511:0] line_val;
  logic         rden_d;

  int n_checks = 0;
  int n_fail   = 0;

  mem_line_read_responder #(.LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .araddr_i     (araddr),
    .arlen_i      (arlen),
    .arburst_i    (arburst),
    .arvalid_i    (arvalid),
    .arready_o    (arready_o),
    .rdata_o      (rdata_o),
    .rresp_o      (rresp_o),
    .rlast_o      (rlast_o),
    .rvalid_o     (rvalid_o),
    .rready_i     (rready),
    .line_rden_o  (line_rden_o),
    .line_raddr_o (line_raddr_o),
    .line_rdata_i (line_rdata_i)
  );

  always #5 clk = ~clk;

  // Backing store: real data only in the cycle after the read strobe.
  always @(posedge clk) rden_d <= line_rden_o;
  assign line_rdata_i = rden_d ? line_val : {512{1'b1}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input bit pat, input int j);
    return pat ? (64'hFEDC_BA98_0000_0000 + 64'(j)) : (64'h0101_0101_0101_0101 * 64'(j));
  endfunction

  function automatic logic [511:0] make_line(input bit pat);
    logic [511:0] l;
    for (int j = 0; j < 8; j++) l[511-64*j -: 64] = word_of(pat, j);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input string tag, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input bit pat, input bit exp_err,
                           input int bp_beat, input int bp_cycles, input bit hold,
                           output logic [63:0] first_d, output logic [63:0] last_d);
    int n, k, stall, rden_cnt, last_cyc, wait_n, start;
    bit done, seen;
    logic [63:0] exp_d;
    first_d  = '0;
    last_d   = '0;
    line_val = make_line(pat);
    araddr   = addr;
    arlen    = len;
    arburst  = burst;
    arvalid  = 1'b1;
    rready   = 1'b1;
    wait_n   = 0;
    while (!arready_o && wait_n < 50) begin
      step();
      wait_n++;
    end
    if (!arready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s ar_timeout: arready_o never rose", tag);
      arvalid = 1'b0;
      return;
    end
    step();  // handshake done; now cycle c+1
    arvalid  = hold;
    start    = int'(addr[5:3]);
    n        = 1;
    k        = 0;
    stall    = 0;
    rden_cnt = 0;
    last_cyc = -1;
    done     = 1'b0;
    seen     = 1'b0;
    while (!done && n < int'(LAT) + int'(len) + bp_cycles + 6) begin
      rready = !(rvalid_o && k == bp_beat && stall < bp_cycles);
      check($sformatf("%s arready_busy n=%0d", tag, n), 64'(arready_o), 64'd0);
      if (line_rden_o) begin
        rden_cnt++;
        check($sformatf("%s rden_cycle", tag), 64'(n), 64'(LAT - 2));
        check($sformatf("%s line_raddr", tag), 64'(line_raddr_o), 64'(addr[31:6]));
      end
      if (rvalid_o) begin
        if (!seen) check($sformatf("%s first_rvalid_cycle", tag), 64'(n), 64'(LAT));
        seen  = 1'b1;
        exp_d = exp_err ? 64'd0 : word_of(pat, (start + k) % 8);
        check($sformatf("%s rdata k=%0d", tag, k), rdata_o, exp_d);
        check($sformatf("%s rresp k=%0d", tag, k), 64'(rresp_o), exp_err ? 64'd2 : 64'd0);
        check($sformatf("%s rlast k=%0d", tag, k), 64'(rlast_o), 64'(k == int'(len)));
        if (rready) begin
          if (k == 0) first_d = rdata_o;
          if (k == int'(len)) begin
            last_d   = rdata_o;
            last_cyc = n;
            done     = 1'b1;
          end
          k++;
        end else begin
          stall++;
        end
      end
      step();
      n++;
    end
    check($sformatf("%s beat_count", tag), 64'(k), 64'(int'(len) + 1));
    check($sformatf("%s last_cycle", tag), 64'(last_cyc),
          64'(int'(LAT) + int'(len) + bp_cycles));
    check($sformatf("%s rden_pulses", tag), 64'(rden_cnt), exp_err ? 64'd0 : 64'd1);
    check($sformatf("%s arready_after", tag), 64'(arready_o), 64'd1);
    check($sformatf("%s rvalid_after", tag), 64'(rvalid_o), 64'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    bit          pat;
    bit          err;
    int          bp_beat;
    int          bp_cycles;
    logic [63:0] first;
    logic [63:0] last;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f, l;
    int n, k;

    vecs[0] = '{32'h0000_1000, 4'd7, 2'b10, 1'b0, 1'b0, -1, 0, 64'h0, 64'h0707_0707_0707_0707};
    vecs[1] = '{32'h0000_1028, 4'd7, 2'b10, 1'b0, 1'b0, -1, 0,
                64'h0505_0505_0505_0505, 64'h0404_0404_0404_0404};
    vecs[2] = '{32'h0000_1018, 4'd7, 2'b10, 1'b1, 1'b0, 2, 3,
                64'hFEDC_BA98_0000_0003, 64'hFEDC_BA98_0000_0002};
    vecs[3] = '{32'h0000_1000, 4'd3, 2'b10, 1'b0, 1'b1, -1, 0, 64'h0, 64'h0};
    vecs[4] = '{32'h0000_1000, 4'd7, 2'b00, 1'b0, 1'b1, -1, 0, 64'h0, 64'h0};
    vecs[5] = '{32'h0000_1008, 4'd7, 2'b01, 1'b0, 1'b1, -1, 0, 64'h0, 64'h0};
    vecs[6] = '{32'h0000_3000, 4'd7, 2'b01, 1'b1, 1'b0, -1, 0,
                64'hFEDC_BA98_0000_0000, 64'hFEDC_BA98_0000_0007};
    vecs[7] = '{32'h0000_107F, 4'd7, 2'b10, 1'b1, 1'b0, 7, 2,
                64'hFEDC_BA98_0000_0007, 64'hFEDC_BA98_0000_0006};
    vecs[8] = '{32'h0000_1038, 4'd2, 2'b11, 1'b0, 1'b1, -1, 0, 64'h0, 64'h0};

    rst      = 1'b1;
    araddr   = '0;
    arlen    = '0;
    arburst  = '0;
    arvalid  = 1'b0;
    rready   = 1'b1;
    line_val = '0;
    step();
    step();
    check("reset arready", 64'(arready_o), 64'd1);
    check("reset rvalid", 64'(rvalid_o), 64'd0);
    check("reset rlast", 64'(rlast_o), 64'd0);
    check("reset rresp", 64'(rresp_o), 64'd0);
    check("reset rdata", rdata_o, 64'd0);
    check("reset line_rden", 64'(line_rden_o), 64'd0);
    check("reset line_raddr", 64'(line_raddr_o), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_burst($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].pat,
                vecs[i].err, vecs[i].bp_beat, vecs[i].bp_cycles, 1'b0, f, l);
      check($sformatf("vec%0d first_word", i), f, vecs[i].first);
      check($sformatf("vec%0d last_word", i), l, vecs[i].last);
      step();
    end

    // Back-to-back: arvalid_i stays high through the first burst.
    run_burst("b2b_a", 32'h0000_1028, 4'd7, 2'b10, 1'b0, 1'b0, -1, 0, 1'b1, f, l);
    check("b2b_a last_word", l, 64'h0404_0404_0404_0404);
    check("b2b arvalid_still_high", 64'(arvalid), 64'd1);
    run_burst("b2b_b", 32'h0000_2000, 4'd7, 2'b10, 1'b1, 1'b0, -1, 0, 1'b0, f, l);
    check("b2b_b first_word", f, 64'hFEDC_BA98_0000_0000);
    check("b2b_b last_word", l, 64'hFEDC_BA98_0000_0007);
    step();

    // Reset in the middle of a burst, after three handshakes.
    line_val = make_line(1'b1);
    araddr   = 32'h0000_1010;
    arlen    = 4'd7;
    arburst  = 2'b10;
    arvalid  = 1'b1;
    rready   = 1'b1;
    check("midrst arready_pre", 64'(arready_o), 64'd1);
    step();
    arvalid = 1'b0;
    n = 0;
    k = 0;
    while (k < 3 && n < 40) begin
      if (rvalid_o && rready) k++;
      step();
      n++;
    end
    check("midrst handshakes", 64'(k), 64'd3);
    check("midrst rvalid_before", 64'(rvalid_o), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst rvalid", 64'(rvalid_o), 64'd0);
    check("midrst rdata", rdata_o, 64'd0);
    check("midrst rlast", 64'(rlast_o), 64'd0);
    check("midrst arready", 64'(arready_o), 64'd1);
    step();
    step();
    rst = 1'b0;
    step();
    check("postrst arready", 64'(arready_o), 64'd1);
    check("postrst rvalid", 64'(rvalid_o), 64'd0);
    run_burst("postrst", 32'h0000_2010, 4'd7, 2'b10, 1'b0, 1'b0, -1, 0, 1'b0, f, l);
    check("postrst first_word", f, 64'h0202_0202_0202_0202);
    check("postrst last_word", l, 64'h0101_0101_0101_0101);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
